vga_stream_monitor: RTL and testbench
=====================================

Name: vga_stream_monitor

Overview:
- Receive-side checker for the TinyVGA output byte produced by our screensaver designs.
- Sits in simulation benches and FPGA bring-up builds on the far end of uo_out.
- Recovers sync, checks every timing interval against parameters, and re-emits pixels with x/y coordinates.
- Produces a per-frame pixel checksum and frame counter so cocotb tests can compare frames without dumping VCD.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync and vsync (0 = active-low)

Ports:
clk  in  1  pixel clock, one pixel per cycle
rst  in  1  synchronous active-high reset
vga_in  in  8  TinyVGA byte: [0]R1 [1]G1 [2]B1 [3]VSYNC [4]R0 [5]G0 [6]B0 [7]HSYNC
err_clear  in  1  single-cycle pulse; clears err_flags
locked  out  1  timing lock achieved
pix_valid  out  1  pix_* holds an active-region pixel
pix_x  out  10  active-region column
pix_y  out  10  active-region row
pix_rgb  out  6  {R1,R0,G1,G0,B1,B0}
frame_done  out  1  one-cycle pulse when frame_sum and frame_count update
frame_count  out  16  completed frames since lock, wraps at 2^16
frame_sum  out  16  sum mod 2^16 of pix_rgb over the last completed frame
err_flags  out  4  sticky errors: [0] line length, [1] hsync width, [2] frame length, [3] vsync width

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset: every output is 0, state is SEARCH, and all counters and accumulators are 0. A mid-frame reset takes effect at the next edge and lock must be reacquired from scratch.
- Input path: vga_in is registered once (stage 1). pix_* are valid at stage 2, two cycles after the byte appears on vga_in.
- Derived constants: H_TOTAL = 800 and V_TOTAL = 525 for the defaults.
- HS edge: hsync goes from inactive to asserted between consecutive stage-1 samples.
  - hcnt is 11 bits, reset to 0 on the HS edge cycle, +1 per cycle otherwise, saturating at 2047.
- Vsync sampling: vsync is sampled only on HS edges.
  - VS edge: vsync asserted at this HS edge and not asserted at the previous one.
  - vcnt is 10 bits, reset to 0 on a VS edge, +1 on each other HS edge, saturating at 1023.
- Active region: hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
  - pix_x = hcnt - (H_SYNC+H_BACK); pix_y = vcnt - (V_SYNC+V_BACK).
  - pix_valid is 1 only in LOCKED and in the active region. pix_x, pix_y and pix_rgb are 0 when pix_valid is 0.
- State machine:
  - SEARCH: wait for an HS edge, then go to HLOCK.
  - HLOCK: on a VS edge, go to LOCKED if every line period since entering HLOCK equalled H_TOTAL. Otherwise stay in HLOCK and restart the check.
  - LOCKED: any timing error returns to SEARCH on the next cycle.
  - locked = (state == LOCKED).
- Checks, enabled only in LOCKED:
  - [0] set when an HS edge occurs with hcnt+1 != H_TOTAL, or when hcnt reaches H_TOTAL with no edge (set at that cycle).
  - [1] set when the hsync deassert cycle gives an asserted width != H_SYNC.
  - [2] set when a VS edge occurs with vcnt+1 != V_TOTAL, or when vcnt reaches V_TOTAL with no edge.
  - [3] set when vsync is first sampled inactive at an HS edge and its asserted-line count != V_SYNC.
- Error and clear precedence:
  - err_clear clears all four flags.
  - If a new error occurs in the same cycle as err_clear, that flag is set; the new error wins.
  - Flags never clear on relock.
- Frame accounting:
  - The VS edge that enters LOCKED zeroes the accumulator and does not pulse frame_done.
  - Every later VS edge in LOCKED with no error during the frame:
    - frame_sum <= accumulator;
    - frame_count += 1;
    - frame_done pulses for 1 cycle;
    - the accumulator restarts at 0 in the same cycle.
  - A VS edge that ends a frame containing an error performs none of these updates.
  - Accumulator: 16-bit, adds zero-extended pix_rgb whenever pix_valid is 1, wraps modulo 2^16.
- Polarity: SYNC_ACTIVE=1 inverts the asserted sense of both syncs. No other change.

Test Plan:
1. Nominal 640x480 timing, 3 frames, rgb = x mod 64 -> locked rises at the first VS edge; 2 frame_done pulses; frame_sum = 0xA800; frame_count = 2; err_flags = 0; 307200 pix_valid cycles per frame.
2. Check pixel alignment, all-black frame with a single white pixel at (639,479) -> pix_x=639, pix_y=479, pix_rgb=6'h3F exactly 2 cycles after input; frame_sum = 63.
3. In LOCKED, inject one 799-clock line -> err_flags[0]=1, locked=0 next cycle; no frame_done for that frame; pulse err_clear -> err_flags=0; relock at the next good VS edge.
4. Inject a 95-pixel hsync in LOCKED -> err_flags=4'b0010. Separately, inject a 524-line frame -> err_flags[2]=1. Separately, inject a 3-line vsync -> err_flags[3]=1.
5. Assert err_clear in the same cycle a line-length error is detected -> err_flags[0] remains 1.
6. Assert rst mid-frame while locked -> all outputs 0 next cycle; locked returns after the next VS edge; frame_count restarts at 0.

Source files
------------

// File: rtl/vga_stream_monitor.sv
// Receive-side checker for the TinyVGA output byte: recovers sync, validates timing,
// re-emits active pixels with coordinates and keeps a per-frame checksum and frame counter.
module vga_stream_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_in,
  input  logic        err_clear,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [15:0] frame_sum,
  output logic [3:0]  err_flags
);

  localparam logic        SYNC_LVL  = (SYNC_ACTIVE != 0);
  localparam logic [10:0] H_TOTAL_C = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
  localparam logic [10:0] H_START_C = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END_C   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_TOTAL_C = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [9:0]  V_SYNC_C  = 10'(V_SYNC);
  localparam logic [9:0]  V_START_C = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END_C   = 10'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  state_t      state;
  logic        hs_act_p1, hs_act_p2, vs_act_p1, vs_prev;
  logic [5:0]  rgb_p1;
  logic [10:0] hcnt, hcnt_inc, hcnt_nxt;
  logic [9:0]  vcnt, vcnt_inc, vcnt_nxt;
  logic        hs_edge, hs_fall, vs_edge, vs_end;
  logic        line_bad, hsw_bad, frame_bad, vsw_bad;
  logic [3:0]  err_new;
  logic        line_ok, in_active, vld_p1, lock_enter, frame_upd;
  logic [15:0] acc;

  // Stage 1: register the incoming byte; syncs are kept as "asserted" flags
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_act_p1 <= 1'b1;
      hs_act_p2 <= 1'b1;
      vs_act_p1 <= 1'b0;
    end else begin
      hs_act_p1 <= (vga_in[7] == SYNC_LVL);
      hs_act_p2 <= hs_act_p1;
      vs_act_p1 <= (vga_in[3] == SYNC_LVL);
    end
  end

  always_ff @(posedge clk) begin
    rgb_p1 <= {vga_in[0], vga_in[4], vga_in[1], vga_in[5], vga_in[2], vga_in[6]};
  end

  assign hs_edge  = hs_act_p1 & ~hs_act_p2;
  assign hs_fall  = ~hs_act_p1 & hs_act_p2;
  assign vs_edge  = hs_edge & vs_act_p1 & ~vs_prev;
  assign vs_end   = hs_edge & ~vs_act_p1 & vs_prev;
  assign hcnt_inc = hcnt + 11'd1;
  assign vcnt_inc = vcnt + 10'd1;
  assign hcnt_nxt = hs_edge ? 11'd0 : sat_inc11(hcnt);
  assign vcnt_nxt = !hs_edge ? vcnt : (vs_edge ? 10'd0 : sat_inc10(vcnt));

  // hcnt/vcnt hold the count of the previous sample, so "+1" is the measured length
  assign line_bad  = hs_edge ? (hcnt_inc != H_TOTAL_C) : (hcnt_nxt == H_TOTAL_C);
  assign hsw_bad   = hs_fall && (hcnt_inc != H_SYNC_C);
  assign frame_bad = (vs_edge && (vcnt_inc != V_TOTAL_C)) ||
                     (hs_edge && !vs_edge && (vcnt_nxt == V_TOTAL_C));
  assign vsw_bad   = vs_end && (vcnt_inc != V_SYNC_C);
  assign err_new   = (state == LOCKED) ? {vsw_bad, frame_bad, hsw_bad, line_bad} : 4'b0000;

  assign in_active  = (hcnt_nxt >= H_START_C) && (hcnt_nxt < H_END_C) &&
                      (vcnt_nxt >= V_START_C) && (vcnt_nxt < V_END_C);
  assign vld_p1     = (state == LOCKED) && in_active;
  assign lock_enter = (state == HLOCK) && vs_edge && line_ok && !line_bad;
  assign frame_upd  = (state == LOCKED) && vs_edge && (err_new == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt    <= 11'd0;
      vcnt    <= 10'd0;
      vs_prev <= 1'b1;
    end else begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
      if (hs_edge) vs_prev <= vs_act_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SEARCH;
      locked  <= 1'b0;
      line_ok <= 1'b0;
    end else begin
      case (state)
        SEARCH: if (hs_edge) begin
          state   <= HLOCK;
          line_ok <= 1'b1;
        end
        HLOCK: begin
          if (vs_edge) begin
            if (lock_enter) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
            line_ok <= 1'b1;
          end else if (line_bad) begin
            line_ok <= 1'b0;
          end
        end
        LOCKED: if (err_new != 4'b0000) begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: pixel outputs, zeroed outside the locked active region
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_x     <= 10'd0;
      pix_y     <= 10'd0;
      pix_rgb   <= 6'd0;
    end else begin
      pix_valid <= vld_p1;
      pix_x     <= vld_p1 ? 10'(hcnt_nxt - H_START_C) : 10'd0;
      pix_y     <= vld_p1 ? (vcnt_nxt - V_START_C) : 10'd0;
      pix_rgb   <= vld_p1 ? rgb_p1 : 6'd0;
    end
  end

  // A new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) err_flags <= 4'b0000;
    else     err_flags <= (err_clear ? 4'b0000 : err_flags) | err_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= 16'd0;
      frame_sum   <= 16'd0;
      frame_count <= 16'd0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_upd;
      if (frame_upd) begin
        frame_sum   <= acc;
        frame_count <= frame_count + 16'd1;
        acc         <= 16'd0;
      end else if (lock_enter) begin
        acc <= 16'd0;
      end else if (pix_valid) begin
        acc <= acc + {10'd0, pix_rgb};
      end
    end
  end

endmodule

// File: tb/tb_vga_stream_monitor.sv
// Directed bench for vga_stream_monitor using a reduced 8x4 raster (15x9 total) to keep frames short.
module tb_vga_stream_monitor;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic SYNC_LVL = 1'b0;
  localparam logic [7:0] IDLE = 8'h88;

  logic        clk = 1'b0;
  logic        rst, err_clear;
  logic [7:0]  vga_in;
  logic        locked, pix_valid, frame_done;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic [15:0] frame_count, frame_sum;
  logic [3:0]  err_flags;

  always #5 clk = ~clk;

  vga_stream_monitor #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(0)
  ) dut (
    .clk(clk), .rst(rst), .vga_in(vga_in), .err_clear(err_clear),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_done(frame_done), .frame_count(frame_count),
    .frame_sum(frame_sum), .err_flags(err_flags)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int pix_err = 0;
  int vld_run = 0;
  int vld_last = 0;
  logic [9:0] last_x = 10'd0, last_y = 10'd0;
  logic [5:0] last_rgb = 6'd0;
  logic       clr_req = 1'b0;
  logic       exp_act0 = 1'b0, exp_act1 = 1'b0;
  logic [9:0] exp_x0 = 10'd0, exp_x1 = 10'd0, exp_y0 = 10'd0, exp_y1 = 10'd0;
  logic [5:0] exp_rgb0 = 6'd0, exp_rgb1 = 6'd0;

  // Output monitor: pixel alignment against the byte driven one put earlier
  always @(posedge clk) begin
    #1;
    if (rst) begin
      vld_run <= 0;
    end else if (frame_done) begin
      done_cnt <= done_cnt + 1;
      vld_last <= vld_run;
      vld_run  <= 0;
    end else if (pix_valid) begin
      vld_run <= vld_run + 1;
    end
    if (pix_valid) begin
      last_x   <= pix_x;
      last_y   <= pix_y;
      last_rgb <= pix_rgb;
      if (!exp_act1 || pix_x != exp_x1 || pix_y != exp_y1 || pix_rgb != exp_rgb1)
        pix_err <= pix_err + 1;
    end else if (pix_x != 10'd0 || pix_y != 10'd0 || pix_rgb != 6'd0) begin
      pix_err <= pix_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] enc(input logic [5:0] rgb, input logic hs, input logic vs);
    logic [7:0] b;
    b[0] = rgb[5]; b[4] = rgb[4];
    b[1] = rgb[3]; b[5] = rgb[2];
    b[2] = rgb[1]; b[6] = rgb[0];
    b[3] = vs ? SYNC_LVL : ~SYNC_LVL;
    b[7] = hs ? SYNC_LVL : ~SYNC_LVL;
    return b;
  endfunction

  function automatic logic [5:0] pat_rgb(input int pat, input logic [9:0] x, input logic [9:0] y);
    if (pat == 0) return 6'(int'(x) * 9);
    return (x == 10'(HA - 1) && y == 10'(VA - 1)) ? 6'h3F : 6'h00;
  endfunction

  task automatic put(input logic [7:0] b, input logic act, input logic [9:0] x,
                     input logic [9:0] y, input logic [5:0] rgb, input logic clr);
    @(negedge clk);
    vga_in    = b;
    err_clear = clr | clr_req;
    clr_req   = 1'b0;
    exp_act1 = exp_act0; exp_x1 = exp_x0; exp_y1 = exp_y0; exp_rgb1 = exp_rgb0;
    exp_act0 = act;      exp_x0 = x;      exp_y0 = y;      exp_rgb0 = rgb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(IDLE, 1'b0, 10'd0, 10'd0, 6'd0, 1'b0);
  endtask

  // bad_v: line one clock short; bad_hs_v: hsync one clock short; clr_v: err_clear at h=1
  task automatic send_frame(input int nlines, input int vsw, input int pat,
                            input int bad_v, input int bad_hs_v, input int clr_v);
    int len, hsw;
    logic act;
    logic [9:0] x, y;
    logic [5:0] rgb;
    for (int v = 0; v < nlines; v++) begin
      len = (v == bad_v) ? HT - 1 : HT;
      hsw = (v == bad_hs_v) ? HS - 1 : HS;
      for (int h = 0; h < len; h++) begin
        act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        x   = act ? 10'(h - (HS + HB)) : 10'd0;
        y   = act ? 10'(v - (VS + VB)) : 10'd0;
        rgb = act ? pat_rgb(pat, x, y) : 6'd0;
        put(enc(rgb, h < hsw, v < vsw), act, x, y, rgb, (v == clr_v) && (h == 1));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    chk({tag, "_pix_rgb"}, 32'(pix_rgb), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    chk({tag, "_frame_sum"}, 32'(frame_sum), 32'd0);
    chk({tag, "_err_flags"}, 32'(err_flags), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    err_clear = 1'b0;
    vga_in = IDLE;
    idle(3);
    check_zero("reset");
    rst = 1'b0;
    idle(3);

    // Nominal frames: lock at frame 1 start, frame_done at frames 2 and 3 starts
    for (int f = 0; f < 4; f++) send_frame(VT, VS, 0, -1, -1, -1);
    chk("nom_locked", 32'(locked), 32'd1);
    chk("nom_done_pulses", 32'(done_cnt), 32'd2);
    chk("nom_frame_count", 32'(frame_count), 32'd2);
    chk("nom_frame_sum", 32'(frame_sum), 32'h03F0);
    chk("nom_err_flags", 32'(err_flags), 32'd0);
    chk("nom_valid_per_frame", 32'(vld_last), 32'(HA * VA));
    chk("nom_pix_align", 32'(pix_err), 32'd0);

    // Single white pixel in the bottom-right corner
    send_frame(VT, VS, 1, -1, -1, -1);
    chk("corner_x", 32'(last_x), 32'(HA - 1));
    chk("corner_y", 32'(last_y), 32'(VA - 1));
    chk("corner_rgb", 32'(last_rgb), 32'h3F);
    send_frame(VT, VS, 0, -1, -1, -1);
    chk("corner_frame_sum", 32'(frame_sum), 32'd63);
    chk("corner_frame_count", 32'(frame_count), 32'd4);

    // Short line while locked, then clear and relock
    send_frame(VT, VS, 0, 5, -1, -1);
    chk("short_line_err", 32'(err_flags), 32'b0001);
    chk("short_line_unlocked", 32'(locked), 32'd0);
    chk("short_line_count", 32'(frame_count), 32'd5);
    clr_req = 1'b1;
    send_frame(VT, VS, 0, -1, -1, -1);
    chk("clear_err", 32'(err_flags), 32'd0);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_count", 32'(frame_count), 32'd5);
    chk("relock_done_pulses", 32'(done_cnt), 32'd5);

    // err_clear in the same cycle the line error is detected
    send_frame(VT, VS, 0, 5, -1, 6);
    chk("clr_vs_err", 32'(err_flags), 32'b0001);
    chk("clr_vs_err_unlocked", 32'(locked), 32'd0);
    chk("clr_vs_err_count", 32'(frame_count), 32'd6);

    // Short hsync
    clr_req = 1'b1;
    send_frame(VT, VS, 0, -1, 5, -1);
    chk("hsync_width_err", 32'(err_flags), 32'b0010);
    chk("hsync_width_unlocked", 32'(locked), 32'd0);

    // Short frame, reported at the following VS edge
    clr_req = 1'b1;
    send_frame(VT, VS, 0, -1, -1, -1);
    chk("pre_short_frame_err", 32'(err_flags), 32'd0);
    chk("pre_short_frame_locked", 32'(locked), 32'd1);
    send_frame(VT - 1, VS, 0, -1, -1, -1);
    chk("short_frame_locked", 32'(locked), 32'd1);
    chk("short_frame_count", 32'(frame_count), 32'd7);
    send_frame(VT, VS, 0, -1, -1, -1);
    chk("short_frame_err", 32'(err_flags), 32'b0100);
    chk("short_frame_unlocked", 32'(locked), 32'd0);
    chk("short_frame_no_update", 32'(frame_count), 32'd7);

    // Long vsync
    clr_req = 1'b1;
    send_frame(VT, VS + 1, 0, -1, -1, -1);
    chk("vsync_width_err", 32'(err_flags), 32'b1000);
    chk("vsync_width_unlocked", 32'(locked), 32'd0);

    // Mid-frame reset while locked
    send_frame(5, VS, 0, -1, -1, -1);
    chk("pre_reset_locked", 32'(locked), 32'd1);
    rst = 1'b1;
    idle(1);
    check_zero("midreset");
    rst = 1'b0;
    idle(4);
    send_frame(VT, VS, 0, -1, -1, -1);
    send_frame(VT, VS, 0, -1, -1, -1);
    chk("reset_relock", 32'(locked), 32'd1);
    chk("reset_count_zero", 32'(frame_count), 32'd0);
    send_frame(VT, VS, 0, -1, -1, -1);
    chk("reset_count_one", 32'(frame_count), 32'd1);
    chk("reset_frame_sum", 32'(frame_sum), 32'h03F0);
    chk("reset_valid_per_frame", 32'(vld_last), 32'(HA * VA));
    chk("final_pix_align", 32'(pix_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
